// File: rtl/display_scheduler_if.sv
// Signal bundle between the calculator core, the BCD converter and the 7-segment display path.
interface display_scheduler_if;
   logic        result_valid;
   logic [31:0] result_in;
   logic        result_is_float;
   logic        entry_active;
   logic        manual_page;
   logic        auto_scroll_en;
   logic        conversion_ready;
   logic [39:0] bcd_in;
   logic        conversion_en;
   logic [31:0] result_latched;
   logic [1:0]  select;
   logic [1:0]  display_mode;
   logic        busy;
   logic        conv_error;

   modport master (
      output result_valid, result_in, result_is_float, entry_active, manual_page,
             auto_scroll_en, conversion_ready, bcd_in,
      input  conversion_en, result_latched, select, display_mode, busy, conv_error
   );

   modport slave (
      input  result_valid, result_in, result_is_float, entry_active, manual_page,
             auto_scroll_en, conversion_ready, bcd_in,
      output conversion_en, result_latched, select, display_mode, busy, conv_error
   );
endinterface

// File: rtl/display_scheduler.sv
// Sequences result display: latches ALU results, kicks the BCD converter with a timeout,
// and pages the 10-digit result through 4-digit display windows.
module display_scheduler #(
   parameter int PAGE_TICKS = 100_000_000,
   parameter int TIMEOUT    = 64
) (
   input logic           CLK100MHz,
   input logic           reset,
   display_scheduler_if.slave bus
);
   localparam int TW = $clog2(PAGE_TICKS);
   localparam int WW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {S_INPUT, S_START, S_WAIT, S_SHOW, S_ERROR} state_t;

   state_t          state, state_n;
   logic            is_float, float_n;
   logic [TW-1:0]   tick_cnt, tick_n;
   logic [WW-1:0]   wait_cnt, wait_n;
   logic [31:0]     latch_n;
   logic [1:0]      page_n, sel_n, num_pages, page_inc, page_next;

   // Sign digit lives on the top page, so negative results always need all three pages.
   always_comb begin
      if (bus.bcd_in[39:32] != '0 || bus.result_latched[31]) num_pages = 2'd3;
      else if (bus.bcd_in[31:16] != '0)                      num_pages = 2'd2;
      else                                                   num_pages = 2'd1;
   end

   always_comb begin
      page_inc = bus.display_mode + 2'd1;
      unique case (num_pages)
         2'd3:    page_next = (page_inc == 2'd3) ? 2'd0 : page_inc;
         2'd2:    page_next = {1'b0, page_inc[0]};
         default: page_next = 2'd0;
      endcase
   end

   always_comb begin
      state_n = state;
      float_n = is_float;
      latch_n = bus.result_latched;
      page_n  = bus.display_mode;
      tick_n  = tick_cnt;
      wait_n  = wait_cnt;
      if (bus.result_valid) begin
         latch_n = bus.result_in;
         float_n = bus.result_is_float;
         page_n  = '0;
         tick_n  = '0;
         wait_n  = '0;
         state_n = bus.result_is_float ? S_SHOW : S_START;
      end else begin
         unique case (state)
            S_INPUT: state_n = S_INPUT;
            S_START: begin
               state_n = S_WAIT;
               wait_n  = '0;
            end
            S_WAIT: begin
               wait_n = wait_cnt + 1'b1;
               // First WAIT cycle ignores ready so a level left over from the last job is not taken.
               if (wait_cnt != '0 && bus.conversion_ready) state_n = S_SHOW;
               else if (wait_cnt == WW'(TIMEOUT - 1))      state_n = S_ERROR;
            end
            S_SHOW: begin
               if (bus.entry_active) state_n = S_INPUT;
               else if (!is_float) begin
                  tick_n = bus.auto_scroll_en ? tick_cnt + 1'b1 : '0;
                  if (bus.manual_page ||
                      (bus.auto_scroll_en && tick_cnt == TW'(PAGE_TICKS - 1))) begin
                     page_n = page_next;
                     tick_n = '0;
                  end
               end
            end
            S_ERROR: if (bus.entry_active) state_n = S_INPUT;
            default: state_n = S_INPUT;
         endcase
      end
      if (state_n != S_SHOW || float_n) begin
         page_n = '0;
         tick_n = '0;
      end
      unique case (state_n)
         S_SHOW:  sel_n = float_n ? 2'b10 : 2'b01;
         S_ERROR: sel_n = 2'b10;
         default: sel_n = 2'b00;
      endcase
   end

   always_ff @(posedge CLK100MHz or posedge reset) begin
      if (reset) begin
         state              <= S_INPUT;
         is_float           <= 1'b0;
         tick_cnt           <= '0;
         wait_cnt           <= '0;
         bus.result_latched <= '0;
         bus.display_mode   <= '0;
         bus.select         <= '0;
         bus.conversion_en  <= 1'b0;
         bus.busy           <= 1'b0;
         bus.conv_error     <= 1'b0;
      end else begin
         state              <= state_n;
         is_float           <= float_n;
         tick_cnt           <= tick_n;
         wait_cnt           <= wait_n;
         bus.result_latched <= latch_n;
         bus.display_mode   <= page_n;
         bus.select         <= sel_n;
         bus.conversion_en  <= (state_n == S_START);
         bus.busy           <= (state_n == S_START) || (state_n == S_WAIT);
         bus.conv_error     <= (state_n == S_ERROR);
      end
   end
endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with a per-cycle reference model and literal checkpoints.
module tb_display_scheduler;
   localparam int PT = 8;
   localparam int TO = 6;

   logic CLK100MHz = 1'b0;
   logic reset     = 1'b1;
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   conv_cycles = 0;
   int   base;

   display_scheduler_if bus();

   display_scheduler #(.PAGE_TICKS(PT), .TIMEOUT(TO)) dut (
      .CLK100MHz(CLK100MHz),
      .reset(reset),
      .bus(bus)
   );

   always #5 CLK100MHz = ~CLK100MHz;

   // Reference model: what the display should be showing, in abstract phases.
   localparam int P_IDLE = 0, P_CONV = 1, P_WAITING = 2, P_INT = 3, P_FLT = 4, P_ERR = 5;
   int          m_phase = P_IDLE;
   int          m_age   = 0;
   int          m_ticks = 0;
   int          m_page  = 0;
   logic [31:0] m_lat   = '0;

   function automatic int npages(logic [39:0] b, logic [31:0] r);
      if (b[39:32] != 0 || r[31]) return 3;
      if (b[31:16] != 0) return 2;
      return 1;
   endfunction

   always @(posedge CLK100MHz or posedge reset) begin
      if (reset) begin
         m_phase = P_IDLE; m_age = 0; m_ticks = 0; m_page = 0; m_lat = '0;
      end else if (bus.result_valid) begin
         m_lat = bus.result_in; m_page = 0; m_ticks = 0;
         m_phase = bus.result_is_float ? P_FLT : P_CONV;
      end else begin
         case (m_phase)
            P_CONV: begin m_phase = P_WAITING; m_age = 1; end
            P_WAITING: begin
               if (m_age > 1 && bus.conversion_ready) begin m_phase = P_INT; m_page = 0; m_ticks = 0; end
               else if (m_age == TO) m_phase = P_ERR;
               else m_age++;
            end
            P_INT: begin
               if (bus.entry_active) m_phase = P_IDLE;
               else begin
                  m_ticks = bus.auto_scroll_en ? m_ticks + 1 : 0;
                  if (bus.manual_page || m_ticks == PT) begin
                     m_page = (m_page + 1) % npages(bus.bcd_in, m_lat);
                     m_ticks = 0;
                  end
               end
            end
            P_FLT, P_ERR: if (bus.entry_active) m_phase = P_IDLE;
            default: ;
         endcase
         if (m_phase != P_INT) m_page = 0;
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge CLK100MHz) begin
      if (!reset) begin
         chk("cmp_conversion_en", 32'(bus.conversion_en), 32'(m_phase == P_CONV));
         chk("cmp_busy", 32'(bus.busy), 32'(m_phase == P_CONV || m_phase == P_WAITING));
         chk("cmp_conv_error", 32'(bus.conv_error), 32'(m_phase == P_ERR));
         chk("cmp_select", 32'(bus.select),
             (m_phase == P_INT) ? 32'd1 : (m_phase == P_FLT || m_phase == P_ERR) ? 32'd2 : 32'd0);
         chk("cmp_display_mode", 32'(bus.display_mode), 32'(m_page));
         chk("cmp_result_latched", bus.result_latched, m_lat);
      end
   end

   always @(posedge CLK100MHz) if (bus.conversion_en) conv_cycles++;

   task automatic step(int n);
      repeat (n) @(posedge CLK100MHz);
      #1;
   endtask

   task automatic send(logic [31:0] v, logic f);
      bus.result_in = v; bus.result_is_float = f; bus.result_valid = 1'b1;
      step(1);
      bus.result_valid = 1'b0;
   endtask

   task automatic leave_to_input();
      bus.entry_active = 1'b1;
      step(1);
      bus.entry_active = 1'b0;
      chk("exit_select", 32'(bus.select), 32'd0);
   endtask

   initial begin
      bus.result_valid = 0; bus.result_in = '0; bus.result_is_float = 0; bus.entry_active = 0;
      bus.manual_page = 0; bus.auto_scroll_en = 0; bus.conversion_ready = 0; bus.bcd_in = '0;
      step(2);
      chk("reset_select", 32'(bus.select), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_conversion_en", 32'(bus.conversion_en), 32'd0);
      chk("reset_latched", bus.result_latched, 32'd0);
      reset = 1'b0;
      step(2);

      // Integer result, ready five cycles after the conversion pulse.
      bus.bcd_in = 40'h12_34;
      base = conv_cycles;
      send(32'd1234, 1'b0);
      chk("int_conv_en_n1", 32'(bus.conversion_en), 32'd1);
      chk("int_busy_n1", 32'(bus.busy), 32'd1);
      step(1);
      chk("int_conv_en_n2", 32'(bus.conversion_en), 32'd0);
      step(4);
      bus.conversion_ready = 1'b1;
      step(1);
      bus.conversion_ready = 1'b0;
      chk("int_select", 32'(bus.select), 32'd1);
      chk("int_busy_done", 32'(bus.busy), 32'd0);
      chk("int_latched", bus.result_latched, 32'd1234);
      chk("int_one_pulse", 32'(conv_cycles - base), 32'd1);
      bus.manual_page = 1'b1;
      step(1);
      bus.manual_page = 1'b0;
      chk("int_single_page", 32'(bus.display_mode), 32'd0);
      leave_to_input();

      // Negative result pages through three windows; stale ready in first WAIT cycle.
      bus.bcd_in = 40'h5;
      bus.auto_scroll_en = 1'b1;
      send(-32'sd5, 1'b0);
      step(1);
      bus.conversion_ready = 1'b1;
      step(1);
      chk("page_stale_ready_busy", 32'(bus.busy), 32'd1);
      step(1);
      bus.conversion_ready = 1'b0;
      chk("page_select", 32'(bus.select), 32'd1);
      step(7);
      chk("page_dm_s7", 32'(bus.display_mode), 32'd0);
      step(1);
      chk("page_dm_s8", 32'(bus.display_mode), 32'd1);
      step(8);
      chk("page_dm_s16", 32'(bus.display_mode), 32'd2);
      step(8);
      chk("page_dm_wrap", 32'(bus.display_mode), 32'd0);
      step(7);
      bus.manual_page = 1'b1;
      step(1);
      bus.manual_page = 1'b0;
      chk("page_coincide_once", 32'(bus.display_mode), 32'd1);
      step(8);
      chk("page_dm_after_coincide", 32'(bus.display_mode), 32'd2);
      bus.auto_scroll_en = 1'b0;
      leave_to_input();

      // Timeout with no ready.
      send(32'd77, 1'b0);
      step(TO);
      chk("to_busy_last", 32'(bus.busy), 32'd1);
      chk("to_err_early", 32'(bus.conv_error), 32'd0);
      step(1);
      chk("to_conv_error", 32'(bus.conv_error), 32'd1);
      chk("to_select_dash", 32'(bus.select), 32'd2);
      chk("to_busy_clear", 32'(bus.busy), 32'd0);
      leave_to_input();
      chk("to_error_cleared", 32'(bus.conv_error), 32'd0);

      // Restart mid-WAIT; stale ready across START and first WAIT cycle.
      base = conv_cycles;
      send(32'd100, 1'b0);
      step(2);
      send(32'd200, 1'b0);
      chk("rs_conv_en", 32'(bus.conversion_en), 32'd1);
      chk("rs_latched", bus.result_latched, 32'd200);
      bus.conversion_ready = 1'b1;
      step(2);
      chk("rs_stale_ignored", 32'(bus.busy), 32'd1);
      step(1);
      bus.conversion_ready = 1'b0;
      chk("rs_select", 32'(bus.select), 32'd1);
      chk("rs_two_pulses", 32'(conv_cycles - base), 32'd2);
      leave_to_input();

      // Float result skips conversion.
      base = conv_cycles;
      send(32'h4048_0000, 1'b1);
      chk("flt_select", 32'(bus.select), 32'd2);
      bus.manual_page = 1'b1;
      step(1);
      bus.manual_page = 1'b0;
      step(1);
      chk("flt_dm", 32'(bus.display_mode), 32'd0);
      chk("flt_no_pulse", 32'(conv_cycles - base), 32'd0);
      leave_to_input();

      // Asynchronous reset during WAIT.
      send(32'd9, 1'b0);
      step(1);
      #2 reset = 1'b1;
      #1;
      chk("ar_busy", 32'(bus.busy), 32'd0);
      chk("ar_select", 32'(bus.select), 32'd0);
      chk("ar_latched", bus.result_latched, 32'd0);
      chk("ar_conv_en", 32'(bus.conversion_en), 32'd0);
      step(2);
      reset = 1'b0;
      base = conv_cycles;
      step(3);
      chk("ar_no_pulse", 32'(conv_cycles - base), 32'd0);
      chk("ar_idle_busy", 32'(bus.busy), 32'd0);
      chk("ar_idle_select", 32'(bus.select), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
